// File: rtl/switch_pkg.sv
// Shared types for the 4-port switch: port masks/indices and the port FSM and packet-type enums.
package switch_pkg;

   localparam int NUM_PORTS = 4;

   typedef logic [3:0] port_mask_t;
   typedef logic [1:0] port_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      ROUTE,
      ARB_WAIT,
      TRANSMIT
   } state_t;

   typedef enum logic [1:0] {
      P_UNICAST,
      P_MULTICAST,
      P_BROADCAST
   } p_type_t;

endpackage

// File: rtl/switch_arbiter_port_age_counter.sv
// Per-port saturating wait counter; flags a requester that has lost arbitration too often.
module port_age_counter #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic waiting,
   input  logic clear,
   output logic urgent
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (waiting && (cnt_q != 4'hf)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign urgent = (cnt_q >= 4'(STARVE_LIMIT));

endmodule

// File: rtl/switch_arbiter.sv
// Round-robin, all-or-nothing multicast output arbiter for the 4-port switch.
// Define ARB_STARVE_EN to add per-port aging that lets starved requesters jump the scan.
module switch_arbiter
   import switch_pkg::*;
#(
   parameter int NUM_PORTS    = switch_pkg::NUM_PORTS,
   parameter int STARVE_LIMIT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] req_target0,
   input  logic [3:0] req_target1,
   input  logic [3:0] req_target2,
   input  logic [3:0] req_target3,
   output logic [3:0] grant,
   output logic [1:0] mux_sel0,
   output logic [1:0] mux_sel1,
   output logic [1:0] mux_sel2,
   output logic [1:0] mux_sel3,
   output logic [3:0] out_valid
);

   port_mask_t [NUM_PORTS-1:0] tgt;
   logic [NUM_PORTS-1:0]       eff_req, win, urgent;
   logic [NUM_PORTS-1:0]       grant_q, grant_d, out_valid_q, out_valid_d;
   port_idx_t  [NUM_PORTS-1:0] mux_sel_q, mux_sel_d;
   port_idx_t                  rr_ptr_q, rr_ptr_d;
   port_idx_t                  idx, first_idx;
   port_mask_t                 claimed;
   logic                       first_set;

   assign tgt = {req_target3, req_target2, req_target1, req_target0};

   // A port still sitting in its grant cycle must not be granted twice.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         eff_req[i] = req[i] & ~grant_q[i] & (tgt[i] != '0);
      end
   end

`ifdef ARB_STARVE_EN
   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_age
      port_age_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_age (
         .clk    (clk),
         .rst_n  (rst_n),
         .waiting(eff_req[g] & ~win[g]),
         .clear  (grant_q[g] | ~req[g]),
         .urgent (urgent[g])
      );
   end
`else
   logic [3:0] unused_starve_limit;
   assign unused_starve_limit = 4'(STARVE_LIMIT);
   assign urgent = '0;
`endif

   // Pass 0 visits urgent ports, pass 1 the rest; both in rr order from rr_ptr.
   always_comb begin
      claimed   = '0;
      win       = '0;
      first_set = 1'b0;
      first_idx = rr_ptr_q;
      idx       = '0;
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            idx = rr_ptr_q + port_idx_t'(k);
            if (eff_req[idx] && (urgent[idx] == (p == 0)) && ((tgt[idx] & claimed) == '0)) begin
               win[idx] = 1'b1;
               claimed  = claimed | tgt[idx];
               if (!first_set) begin
                  first_set = 1'b1;
                  first_idx = idx;
               end
            end
         end
      end
      grant_d  = win;
      rr_ptr_d = first_set ? first_idx + 2'd1 : rr_ptr_q;
   end

   // Masks are still stable during the grant cycle, so they steer the next transmit.
   always_comb begin
      out_valid_d = '0;
      mux_sel_d   = mux_sel_q;
      for (int i = 0; i < NUM_PORTS; i++) begin
         for (int j = 0; j < NUM_PORTS; j++) begin
            if (grant_q[i] && tgt[i][j]) begin
               out_valid_d[j] = 1'b1;
               mux_sel_d[j]   = port_idx_t'(i);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q     <= '0;
         out_valid_q <= '0;
         mux_sel_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         grant_q     <= grant_d;
         out_valid_q <= out_valid_d;
         mux_sel_q   <= mux_sel_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign grant     = grant_q;
   assign out_valid = out_valid_q;
   assign mux_sel0  = mux_sel_q[0];
   assign mux_sel1  = mux_sel_q[1];
   assign mux_sel2  = mux_sel_q[2];
   assign mux_sel3  = mux_sel_q[3];

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed bench for switch_arbiter: a queue-based arbitration model checked every cycle,
// plus literal expectations for each scenario.
module tb_switch_arbiter;

   localparam int SL = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] tgt [4];
   logic [3:0] grant, out_valid;
   logic [1:0] ms0, ms1, ms2, ms3;

   always #5 clk = ~clk;

   switch_arbiter #(.NUM_PORTS(4), .STARVE_LIMIT(SL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_target0(tgt[0]),
      .req_target1(tgt[1]),
      .req_target2(tgt[2]),
      .req_target3(tgt[3]),
      .grant      (grant),
      .mux_sel0   (ms0),
      .mux_sel1   (ms1),
      .mux_sel2   (ms2),
      .mux_sel3   (ms3),
      .out_valid  (out_valid)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [3:0] m_grant = '0;
   logic [3:0] m_ov    = '0;
   logic [1:0] m_sel [4] = '{2'd0, 2'd0, 2'd0, 2'd0};
   int         m_ptr   = 0;
   int         m_age [4] = '{0, 0, 0, 0};

   logic [3:0] mv_nov, mv_claimed, mv_elig, mv_win;
   logic [1:0] mv_nsel [4];
   int         mv_order [$];
   int         mv_first;

   function automatic bit is_urgent(input int i);
`ifdef ARB_STARVE_EN
      return m_age[i] >= SL;
`else
      return (i < 0);
`endif
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_grant = '0;
            m_ov    = '0;
            m_ptr   = 0;
            for (int i = 0; i < 4; i++) begin
               m_sel[i] = 2'd0;
               m_age[i] = 0;
            end
         end else begin
            mv_nov = '0;
            for (int j = 0; j < 4; j++) mv_nsel[j] = m_sel[j];
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++)
                  if (m_grant[i] && tgt[i][j]) begin
                     mv_nov[j]  = 1'b1;
                     mv_nsel[j] = 2'(i);
                  end
            for (int i = 0; i < 4; i++) mv_elig[i] = req[i] && !m_grant[i] && (tgt[i] != 4'd0);
            mv_order.delete();
            for (int u = 1; u >= 0; u--)
               for (int k = 0; k < 4; k++)
                  if (is_urgent((m_ptr + k) % 4) == (u == 1)) mv_order.push_back((m_ptr + k) % 4);
            mv_claimed = '0;
            mv_win     = '0;
            mv_first   = -1;
            foreach (mv_order[n]) begin
               if (mv_elig[mv_order[n]] && ((tgt[mv_order[n]] & mv_claimed) == 4'd0)) begin
                  mv_win[mv_order[n]] = 1'b1;
                  mv_claimed = mv_claimed | tgt[mv_order[n]];
                  if (mv_first < 0) mv_first = mv_order[n];
               end
            end
            for (int i = 0; i < 4; i++) begin
               if (m_grant[i] || !req[i]) m_age[i] = 0;
               else if (mv_elig[i] && !mv_win[i] && m_age[i] < 15) m_age[i] = m_age[i] + 1;
            end
            if (mv_first >= 0) m_ptr = (mv_first + 1) % 4;
            m_grant = mv_win;
            m_ov    = mv_nov;
            for (int j = 0; j < 4; j++) m_sel[j] = mv_nsel[j];
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         chk("cyc_grant", grant, m_grant);
         chk("cyc_out_valid", out_valid, m_ov);
         chk("cyc_mux_sel0", {2'b00, ms0}, {2'b00, m_sel[0]});
         chk("cyc_mux_sel1", {2'b00, ms1}, {2'b00, m_sel[1]});
         chk("cyc_mux_sel2", {2'b00, ms2}, {2'b00, m_sel[2]});
         chk("cyc_mux_sel3", {2'b00, ms3}, {2'b00, m_sel[3]});
      end
   end

   // ---------------- stimulus ----------------
   logic [3:0] gprev = '0;
   logic       got;

   // Ports leave ARB_WAIT the cycle after their grant pulse.
   task automatic cyc();
      @(posedge clk);
      #1;
      req   = req & ~gprev;
      gprev = m_grant;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      rst_n = 1'b1;
      req   = '0;
      for (int i = 0; i < 4; i++) tgt[i] = '0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_grant", grant, 4'b0000);
      chk("rst_out_valid", out_valid, 4'b0000);
      chk("rst_mux_sel", {ms3[0], ms2[0], ms1[0], ms0[0]} | {ms3[1], ms2[1], ms1[1], ms0[1]}, 4'b0000);
      @(posedge clk); #1 rst_n = 1'b1;
      run(1);

      // single unicast, ptr 0 -> 1
      cyc(); req = 4'b0001; tgt[0] = 4'b0100;
      cyc(); @(negedge clk); chk("uni_grant", grant, 4'b0001);
      cyc(); @(negedge clk);
      chk("uni_out_valid", out_valid, 4'b0100);
      chk("uni_mux_sel2", {2'b00, ms2}, 4'd0);
      chk("uni_grant_once", grant, 4'b0000);
      run(2);

      // zero mask is never granted
      cyc(); req = 4'b0001; tgt[0] = 4'b0000;
      run(3); @(negedge clk); chk("zero_mask_grant", grant, 4'b0000);
      req = 4'b0000;

      // request pulse that drops before the sampling edge
      cyc(); req[2] = 1'b1; tgt[2] = 4'b0001;
      @(negedge clk); req[2] = 1'b0;
      cyc(); @(negedge clk); chk("pulse_grant", grant, 4'b0000);

      // port 3 unicast moves ptr 1 -> 0
      cyc(); req = 4'b1000; tgt[3] = 4'b0001;
      run(4);

      // conflict on output 1, ptr 0
      cyc(); tgt[0] = 4'b0010; tgt[1] = 4'b0010; req = 4'b0011;
      cyc(); @(negedge clk); chk("conf_grant_a", grant, 4'b0001);
      cyc(); @(negedge clk);
      chk("conf_grant_b", grant, 4'b0010);
      chk("conf_sel1_a", {2'b00, ms1}, 4'd0);
      chk("conf_out_valid", out_valid, 4'b0010);
      cyc(); @(negedge clk); chk("conf_sel1_b", {2'b00, ms1}, 4'd1);
      run(2);

      // parallel, ptr 2
      cyc(); tgt[0] = 4'b0010; tgt[3] = 4'b0001; req = 4'b1001;
      cyc(); @(negedge clk); chk("par_grant", grant, 4'b1001);
      cyc(); @(negedge clk);
      chk("par_out_valid", out_valid, 4'b0011);
      chk("par_sel0", {2'b00, ms0}, 4'd3);
      run(2);

      // port 1 unicast moves ptr 0 -> 2
      cyc(); req = 4'b0010; tgt[1] = 4'b1000;
      run(4);

      // multicast blocked by unicast, ptr 2
      cyc(); tgt[1] = 4'b1100; tgt[2] = 4'b0100; req = 4'b0110;
      cyc(); @(negedge clk); chk("mc_grant_a", grant, 4'b0100);
      cyc(); @(negedge clk); chk("mc_grant_b", grant, 4'b0010);
      cyc(); @(negedge clk);
      chk("mc_out_valid", out_valid, 4'b1100);
      chk("mc_sel2", {2'b00, ms2}, 4'd1);
      chk("mc_sel3", {2'b00, ms3}, 4'd1);
      run(2);

      // broadcast
      cyc(); tgt[3] = 4'b1111; req = 4'b1000;
      cyc(); @(negedge clk); chk("bc_grant", grant, 4'b1000);
      cyc(); @(negedge clk);
      chk("bc_out_valid", out_valid, 4'b1111);
      chk("bc_sels", {ms3, ms2, ms1, ms0} == 8'hff ? 4'd1 : 4'd0, 4'd1);
      run(2);

      // reset between grant and transmit
      cyc(); req = 4'b0001; tgt[0] = 4'b0010;
      cyc(); @(negedge clk); chk("rg_grant", grant, 4'b0001);
      #1 rst_n = 1'b0; req = '0; gprev = '0;
      #1;
      chk("rg_grant_cleared", grant, 4'b0000);
      chk("rg_out_valid_cleared", out_valid, 4'b0000);
      #1 rst_n = 1'b1;
      cyc(); @(negedge clk); chk("rg_no_transmit", out_valid, 4'b0000);
      run(1);

      // port 2 unicast moves ptr 0 -> 3, so the broadcaster is scanned first
      cyc(); req = 4'b0100; tgt[2] = 4'b1000;
      run(4);

      // port 0 competes against a repeatedly re-requesting broadcaster
      cyc(); tgt[0] = 4'b0001; tgt[3] = 4'b1111; req = 4'b1001;
      got = 1'b0;
      for (int n = 0; n < 6 && !got; n++) begin
         cyc();
         if (!req[3]) req[3] = 1'b1;
         @(negedge clk);
         if (grant[0]) got = 1'b1;
      end
      chk("starve_port0_granted", {3'b000, got}, 4'b0001);
      req[3] = 1'b0;
      run(4);
      req = '0;
      run(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
